// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS-subset controller.
// Holds the state encoding, the instruction class, opcode/funct values,
// ALU operation codes and immediate-extension codes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5,
    S_JMP    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [4:0] {
    C_NOP   = 5'd0,
    C_ADDU  = 5'd1,
    C_SUBU  = 5'd2,
    C_AND   = 5'd3,
    C_OR    = 5'd4,
    C_SLT   = 5'd5,
    C_SLL   = 5'd6,
    C_SRL   = 5'd7,
    C_JR    = 5'd8,
    C_ORI   = 5'd9,
    C_ADDIU = 5'd10,
    C_LUI   = 5'd11,
    C_LW    = 5'd12,
    C_SW    = 5'd13,
    C_BEQ   = 5'd14,
    C_J     = 5'd15,
    C_JAL   = 5'd16,
    C_ILL   = 5'd17
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_LUI = 5'd7;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // R-type ALU classes write rd rather than rt
  function automatic logic is_rtype_alu(input iclass_t c);
    logic r;
    case (c)
      C_ADDU, C_SUBU, C_AND, C_OR, C_SLT, C_SLL, C_SRL: r = 1'b1;
      default:                                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bus. master = controller side,
// slave = datapath side. The illegal port exists only when
// MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_ctrl_if;
  logic [31:0] instruction;
  logic        zero;
  logic        dm_ready;
  logic        PCWr, IRWr, RegWr, MemWr;
  logic        RegDst, Link;
  logic        ALUSrc, MemtoReg, Branch, Jump, JrSel;
  logic        MemRd;
  logic [1:0]  ExtOp;
  logic [4:0]  ALUctr;
  logic        dm_timeout;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  modport master (
    input  instruction, zero, dm_ready,
    output PCWr, IRWr, RegWr, MemWr, RegDst, Link,
    output ALUSrc, MemtoReg, Branch, Jump, JrSel, MemRd,
    output ExtOp, ALUctr, dm_timeout
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output instruction, zero, dm_ready,
    input  PCWr, IRWr, RegWr, MemWr, RegDst, Link,
    input  ALUSrc, MemtoReg, Branch, Jump, JrSel, MemRd,
    input  ExtOp, ALUctr, dm_timeout
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct to instruction-class map.
// Anything outside the supported subset decodes as C_ILL.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  // classify the instruction word currently held in IR
  always_comb begin
    iclass = C_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = C_ADDU;
          FN_SUBU: iclass = C_SUBU;
          FN_AND:  iclass = C_AND;
          FN_OR:   iclass = C_OR;
          FN_SLT:  iclass = C_SLT;
          FN_SLL:  iclass = C_SLL;
          FN_SRL:  iclass = C_SRL;
          FN_JR:   iclass = C_JR;
          default: iclass = C_ILL;
        endcase
      end
      OP_J:     iclass = C_J;
      OP_JAL:   iclass = C_JAL;
      OP_BEQ:   iclass = C_BEQ;
      OP_ADDIU: iclass = C_ADDIU;
      OP_ORI:   iclass = C_ORI;
      OP_LUI:   iclass = C_LUI;
      OP_LW:    iclass = C_LW;
      OP_SW:    iclass = C_SW;
      default:  iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit (FETCH/DECODE/EXE/MEM/WB/BR/JMP).
// Outputs decode from the registered state, latched class and stall
// counter; a MEM access is abandoned after DM_WAIT_MAX cycles without
// dm_ready. Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (unsupported
// instructions trap into HALT and raise illegal).
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [3:0] DM_WAIT_MAX = 4'd15
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  state_t     state_r;
  iclass_t    class_r;
  logic [3:0] stall_r;
  iclass_t    dec_class_s;
  logic       mem_done_s;
  logic       timeout_s;

  mc_decode u_decode (
    .opcode (bus.instruction[31:26]),
    .funct  (bus.instruction[5:0]),
    .iclass (dec_class_s)
  );

  // MEM completion wins over an expiring stall budget
  always_comb begin
    mem_done_s = 1'b0;
    timeout_s  = 1'b0;
    if (state_r == S_MEM) begin
      mem_done_s = bus.dm_ready;
      timeout_s  = !bus.dm_ready && (stall_r >= (DM_WAIT_MAX - 4'd1));
    end else begin
      mem_done_s = 1'b0;
      timeout_s  = 1'b0;
    end
  end

  // sequencer: state, latched class and MEM stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
      class_r <= C_NOP;
      stall_r <= 4'd0;
    end else begin
      case (state_r)
        S_FETCH: state_r <= S_DECODE;
        S_DECODE: begin
          class_r <= dec_class_s;
          case (dec_class_s)
            C_BEQ:            state_r <= S_BR;
            C_J, C_JAL, C_JR: state_r <= S_JMP;
            C_NOP:            state_r <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            C_ILL:            state_r <= S_HALT;
`else
            C_ILL:            state_r <= S_FETCH;
`endif
            default:          state_r <= S_EXE;
          endcase
        end
        S_EXE: begin
          stall_r <= 4'd0;
          if ((class_r == C_LW) || (class_r == C_SW)) begin
            state_r <= S_MEM;
          end else begin
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_done_s) begin
            state_r <= (class_r == C_LW) ? S_WB : S_FETCH;
          end else if (timeout_s) begin
            state_r <= S_FETCH;
          end else begin
            stall_r <= stall_r + 4'd1;
          end
        end
        S_WB, S_BR, S_JMP: state_r <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_HALT:  state_r <= S_HALT;
`else
        S_HALT:  state_r <= S_FETCH;
`endif
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // control strobes; everything is held low while reset is asserted
  always_comb begin
    bus.PCWr       = 1'b0;
    bus.IRWr       = 1'b0;
    bus.RegWr      = 1'b0;
    bus.MemWr      = 1'b0;
    bus.RegDst     = 1'b0;
    bus.Link       = 1'b0;
    bus.ALUSrc     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.Branch     = 1'b0;
    bus.Jump       = 1'b0;
    bus.JrSel      = 1'b0;
    bus.MemRd      = 1'b0;
    bus.ExtOp      = EXT_ZERO;
    bus.ALUctr     = ALU_ADD;
    bus.dm_timeout = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    bus.illegal    = 1'b0;
`endif
    if (reset) begin
      case (state_r)
        S_FETCH: begin
          bus.PCWr = 1'b1;
          bus.IRWr = 1'b1;
        end
        S_EXE: begin
          case (class_r)
            C_ADDU:  bus.ALUctr = ALU_ADD;
            C_SUBU:  bus.ALUctr = ALU_SUB;
            C_AND:   bus.ALUctr = ALU_AND;
            C_OR:    bus.ALUctr = ALU_OR;
            C_SLT:   bus.ALUctr = ALU_SLT;
            C_SLL:   bus.ALUctr = ALU_SLL;
            C_SRL:   bus.ALUctr = ALU_SRL;
            C_ORI: begin
              bus.ALUSrc = 1'b1;
              bus.ExtOp  = EXT_ZERO;
              bus.ALUctr = ALU_OR;
            end
            C_ADDIU, C_LW, C_SW: begin
              bus.ALUSrc = 1'b1;
              bus.ExtOp  = EXT_SIGN;
              bus.ALUctr = ALU_ADD;
            end
            C_LUI: begin
              bus.ALUSrc = 1'b1;
              bus.ExtOp  = EXT_LUI;
              bus.ALUctr = ALU_LUI;
            end
            default: bus.ALUctr = ALU_ADD;
          endcase
        end
        S_MEM: begin
          bus.MemRd      = (class_r == C_LW) && !timeout_s;
          bus.MemWr      = (class_r == C_SW) && !timeout_s;
          bus.dm_timeout = timeout_s;
        end
        S_WB: begin
          bus.RegWr    = 1'b1;
          bus.RegDst   = is_rtype_alu(class_r);
          bus.MemtoReg = (class_r == C_LW);
        end
        S_BR: begin
          bus.Branch = 1'b1;
          bus.PCWr   = bus.zero;
        end
        S_JMP: begin
          bus.Jump  = 1'b1;
          bus.PCWr  = 1'b1;
          bus.Link  = (class_r == C_JAL);
          bus.RegWr = (class_r == C_JAL);
          bus.JrSel = (class_r == C_JR);
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_HALT:  bus.illegal = 1'b1;
`endif
        default: bus.PCWr = 1'b0;
      endcase
    end else begin
      bus.PCWr = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed + randomized bench for mc_ctrl. Expected strobes are
// built per instruction from an op table (class, ALU code, immediate
// handling) and the cycle rules of each instruction kind.
module tb_mc_ctrl;

  localparam logic [3:0] WAIT_MAX = 4'd4;

  logic clk = 1'b0;
  logic reset;
  mc_ctrl_if bus ();

  mc_ctrl #(.DM_WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwr, irwr, regwr, memwr, regdst, link;
    logic       alusrc, memtoreg, branch, jump, jrsel, memrd;
    logic [1:0] extop;
    logic [4:0] aluctr;
    logic       tmo;
  } ov_t;

  // op table: name, opcode, funct, R-type?, ALU code, ALUSrc, ExtOp
  string      OPN [16] = '{"addu", "subu", "and", "or", "slt", "sll", "srl", "jr",
                           "ori", "addiu", "lui", "lw", "sw", "beq", "j", "jal"};
  logic [5:0] OPC [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                           6'h0D, 6'h09, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  logic [5:0] FN  [16] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08,
                           6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  logic       ISR [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [4:0] ALU [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0,
                           5'd3, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  logic       SRC [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0] EXT [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                           2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};

  localparam int I_JR = 7, I_LW = 11, I_SW = 12, I_BEQ = 13, I_J = 14, I_JAL = 15;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic rbit();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic int op_index(input logic [31:0] ins);
    for (int i = 0; i < 16; i++) begin
      if (ISR[i]) begin
        if (ins[31:26] == 6'h00 && ins[5:0] == FN[i]) return i;
      end else if (ins[31:26] == OPC[i]) begin
        return i;
      end
    end
    return -1;
  endfunction

  function automatic ov_t observe();
    ov_t o;
    o.pcwr = bus.PCWr;     o.irwr = bus.IRWr;         o.regwr = bus.RegWr;
    o.memwr = bus.MemWr;   o.regdst = bus.RegDst;     o.link = bus.Link;
    o.alusrc = bus.ALUSrc; o.memtoreg = bus.MemtoReg; o.branch = bus.Branch;
    o.jump = bus.Jump;     o.jrsel = bus.JrSel;       o.memrd = bus.MemRd;
    o.extop = bus.ExtOp;   o.aluctr = bus.ALUctr;     o.tmo = bus.dm_timeout;
    return o;
  endfunction

  task automatic check(input string tag, input logic [2:0] st, input ov_t e);
    ov_t        obs;
    logic [2:0] st_obs;
    obs    = observe();
    st_obs = dut.state_r;
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %h expected %h", tag, obs, e);
    end
    n_assert++;
    assert (st_obs === st) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, st_obs, st);
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    n_assert++;
    assert (bus.illegal === (st == 3'd7)) else begin
      n_fail++;
      $error("FAIL %s illegal: observed %b expected %b", tag, bus.illegal, (st == 3'd7));
    end
`endif
  endtask

  // one cycle: inputs already driven; sample at negedge, then step past posedge
  task automatic cyc(input string tag, input logic [2:0] st, input ov_t e);
    @(negedge clk);
    check(tag, st, e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.dm_ready = rbit();
    bus.zero     = rbit();
  endtask

  // low_cycles: -1 random dm_ready in MEM, else ready once k > low_cycles
  // zmode: -1 random zero in BR; abort_at: MEM cycle to assert reset in (0 none)
  task automatic run_instr(input logic [31:0] ins, input int low_cycles,
                           input int zmode, input int abort_at);
    int    idx;
    string tag;
    ov_t   e;
    logic  rdy, z, done;
    idx = op_index(ins);
    tag = (idx < 0) ? "ill" : OPN[idx];
    bus.instruction = ins;
    noise();
    e = '0; e.pcwr = 1'b1; e.irwr = 1'b1;
    cyc({tag, "/fetch"}, 3'd0, e);
    noise();
    cyc({tag, "/decode"}, 3'd1, '0);
    if (idx < 0) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      for (int h = 0; h < 3; h++) begin
        noise();
        cyc({tag, "/halt"}, 3'd7, '0);
      end
      reset = 1'b0;
      #1;
      check({tag, "/halt_reset"}, 3'd0, '0);
      @(posedge clk);
      #1;
      reset = 1'b1;
`endif
      return;
    end
    if (idx == I_BEQ) begin
      z = (zmode < 0) ? rbit() : (zmode != 0);
      bus.zero = z; bus.dm_ready = rbit();
      e = '0; e.branch = 1'b1; e.pcwr = z;
      cyc({tag, "/br"}, 3'd5, e);
      return;
    end
    if (idx == I_J || idx == I_JAL || idx == I_JR) begin
      noise();
      e = '0; e.jump = 1'b1; e.pcwr = 1'b1;
      e.link = (idx == I_JAL); e.regwr = (idx == I_JAL); e.jrsel = (idx == I_JR);
      cyc({tag, "/jmp"}, 3'd6, e);
      return;
    end
    noise();
    e = '0; e.alusrc = SRC[idx]; e.extop = EXT[idx]; e.aluctr = ALU[idx];
    cyc({tag, "/exe"}, 3'd2, e);
    done = 1'b1;
    if (idx == I_LW || idx == I_SW) begin
      done = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        rdy = (low_cycles < 0) ? ($urandom_range(0, 3) == 0) : (k > low_cycles);
        bus.dm_ready = rdy; bus.zero = rbit();
        if (abort_at == k) begin
          reset = 1'b0;
          #1;
          check({tag, "/abort"}, 3'd0, '0);
          @(posedge clk);
          #1;
          reset = 1'b1;
          return;
        end
        e = '0;
        if (rdy) begin
          e.memrd = (idx == I_LW); e.memwr = (idx == I_SW);
          cyc({tag, "/mem_done"}, 3'd3, e);
          done = 1'b1;
          break;
        end else if (k == int'(WAIT_MAX)) begin
          e.tmo = 1'b1;
          cyc({tag, "/mem_timeout"}, 3'd3, e);
          break;
        end else begin
          e.memrd = (idx == I_LW); e.memwr = (idx == I_SW);
          cyc({tag, "/mem_stall"}, 3'd3, e);
        end
      end
    end
    if (idx != I_SW && done) begin
      noise();
      e = '0; e.regwr = 1'b1; e.regdst = ISR[idx]; e.memtoreg = (idx == I_LW);
      cyc({tag, "/wb"}, 3'd4, e);
    end
  endtask

  initial begin
    logic [31:0] r, ins;
    int          idx;
    reset = 1'b0;
    bus.instruction = 32'h0000_0000;
    bus.dm_ready = 1'b1;
    bus.zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 3'd0, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(32'h0022_1821, -1, -1, 0);   // addu
    run_instr(32'h8C22_0004, 3, -1, 0);    // lw, ready on 4th MEM cycle
    run_instr(32'h1022_0003, -1, 1, 0);    // beq taken
    run_instr(32'h1022_0003, -1, 0, 0);    // beq not taken
    run_instr(32'h0C00_0010, -1, -1, 0);   // jal
    run_instr(32'h03E0_0008, -1, -1, 0);   // jr
    run_instr(32'hAC22_0004, 99, -1, 0);   // sw timeout
    run_instr(32'h3C01_1234, -1, -1, 0);   // lui
    run_instr(32'hAC22_0004, 99, -1, 2);   // sw reset-abort in MEM
    run_instr(32'h8C22_0004, 0, -1, 0);    // lw zero stall

    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 15);
      r   = $urandom;
      if (ISR[idx]) ins = {6'h00, r[25:6], FN[idx]};
      else          ins = {OPC[idx], r[25:0]};
      run_instr(ins, -1, -1, ($urandom_range(0, 9) == 0) ? 1 : 0);
    end

    run_instr(32'hFC00_0000, -1, -1, 0);   // unsupported opcode 0x3F
    run_instr(32'h0022_1821, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-subset datapath. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives every datapath control strobe: register, memory and PC write enables plus mux selects. Decoding is driven by the instruction word and the ALU `zero` flag. Memory states stall on a data-memory ready handshake, so `mc_ctrl` replaces the combinational decoder that sat in front of the single-cycle datapath.

## Interface
Parameters:
- `DM_WAIT_MAX`, default 15: maximum stall cycles in MEM before the access is abandoned. Width is 4 bits; legal range is 1..15.

Ports:
- `clk`  input  1: sole clock; all state changes on the rising edge.
- `reset`  input  1: asynchronous, active-low. 0 clears state immediately.
- `instruction`  input  32: IR contents, valid from DECODE onward.
- `zero`  input  1: ALU zero flag, valid in BR.
- `dm_ready`  input  1: data memory has completed the access this cycle.
- `PCWr`, `IRWr`, `RegWr`, `MemWr`  output  1 each: write enables.
- `RegDst`  output  1: 1 selects rd, 0 selects rt.
- `Link`  output  1: writes PC+4 to register $31.
- `ALUSrc`, `MemtoReg`, `Branch`, `Jump`, `JrSel`  output  1 each: mux selects.
- `MemRd`  output  1: data-memory read request.
- `ExtOp`  output  2: 00 zero-extend, 01 sign-extend, 10 load-upper.
- `ALUctr`  output  5: ALU operation code.
- `dm_timeout`  output  1: one-cycle pulse when a MEM stall exceeds `DM_WAIT_MAX`.

## Operation
- Supported ops: addu, subu, and, or, slt, sll, srl, jr (R-type); ori, addiu, lui, lw, sw, beq, j, jal.
- 3-bit state register. Encodings: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, BR=5, JMP=6, HALT=7.
- DECODE latches an internal instruction class from opcode/funct. All later states decode outputs from state plus the latched class, never from raw `instruction`.
- State transitions:
  - FETCH → DECODE.
  - DECODE → BR for beq.
  - DECODE → JMP for j, jal and jr.
  - DECODE → EXE for all other ops.
  - EXE → MEM for lw and sw.
  - EXE → WB for ALU ops.
  - MEM → WB for lw once `dm_ready`=1.
  - MEM → FETCH for sw once `dm_ready`=1.
  - BR, JMP and WB → FETCH.
- Outputs by state:
  - FETCH: `PCWr`=1, `IRWr`=1.
  - EXE: `ALUSrc`, `ExtOp` and `ALUctr` per op.
  - MEM: `MemRd`=1 for lw. `MemWr`=1 for sw, held until `dm_ready`.
  - WB: `RegWr`=1. `RegDst`=1 for R-type. `MemtoReg`=1 for lw.
  - BR: `Branch`=1; `PCWr`=`zero`.
  - JMP: `Jump`=1, `PCWr`=1. `Link`=`RegWr`=1 for jal. `JrSel`=1 for jr.
- In all other cases, all outputs are 0.
- Per-op control values:
  - sll and srl: `ALUSrc`=0; the ALU takes shamt from the datapath.
  - ori: `ExtOp`=00.
  - addiu, lw, sw: `ExtOp`=01.
  - lui: `ExtOp`=10.
- Cycles per instruction: R-type and imm ALU ops = 4; sw = 4+stall; lw = 5+stall; beq, j, jal, jr = 3.
- Stall counter (4 bits):
  - Clears on MEM entry and increments each MEM cycle while `dm_ready`=0.
  - When the counter reaches `DM_WAIT_MAX`: pulse `dm_timeout`, drop `MemRd`/`MemWr`, go to FETCH. lw then performs no writeback.

## Timing
- Reset (`reset`=0) forces state=FETCH, class=NOP and stall count=0.
- While reset is asserted, all outputs are forced to 0, including `PCWr` and `IRWr`.
- After release, the first rising edge performs a FETCH with `PCWr`=`IRWr`=1.
- Reset asserted mid-instruction aborts the instruction with no partial write; outputs go low in the same cycle.
- `dm_ready` is sampled only in MEM. `dm_ready`=1 in the first MEM cycle gives zero stall.
- If `dm_ready` rises in the same cycle the counter reaches `DM_WAIT_MAX`, the completion wins and `dm_timeout` is not pulsed.
- `zero` is sampled only in BR. `dm_ready`/`zero` outside those states are ignored.
- All outputs are combinational from registered state/class/counter; there are no input-to-output paths except `PCWr`←`zero` in BR and `MemWr`/`MemRd` drop on timeout.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode/funct in DECODE enters HALT.
  - In HALT, all outputs stay 0 until reset.
  - Adds output `illegal` (1 bit): 1 only in HALT.
- Macro not defined:
  - Unsupported instructions decode as NOP: DECODE → FETCH, no writes, 2 cycles.
  - HALT is unreachable and the `illegal` port is absent.

## Structure
- Shared package `mc_pkg` holds:
  - state encodings;
  - instruction-class enum;
  - opcode/funct constants;
  - ALUctr codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6, LUI=7;
  - ExtOp codes.
- One sub-module, `mc_decode`: combinational map from opcode/funct to instruction class, instantiated in DECODE.

## Test plan
- Reset release, then addu (0x00221821) with `dm_ready`=0: states 0,1,2,4,0. `RegWr`=1 and `RegDst`=1 only in WB; `ALUctr`=ADD in EXE.
- lw (0x8C220004) with `dm_ready` low 3 cycles, then high: MEM lasts 4 cycles with `MemRd`=1. WB has `MemtoReg`=1, `RegWr`=1. Total 8 cycles.
- beq (0x10220003) with `zero`=1, then `zero`=0: BR has `Branch`=1 and `PCWr`=1, then `PCWr`=0. Each instruction takes 3 cycles.
- jal (0x0C000010): JMP has `Jump`=1, `Link`=1, `RegWr`=1, `PCWr`=1. jr (0x03E00008): `JrSel`=1 and `RegWr`=0.
- sw with `DM_WAIT_MAX`=4 and `dm_ready` held 0: `dm_timeout` pulses once in the 4th MEM cycle, then FETCH. `MemWr` is never 1 after the timeout cycle.
- Reset asserted in MEM of sw: outputs go to 0 asynchronously. Release gives FETCH. With the macro on, opcode 0x3F enters HALT with `illegal`=1, exited only by reset.
